fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the pipelined instruction memory.
- Generates the word-indexed fetch address each cycle, applies stall, flush and branch/jump redirects, and tracks a valid bit and PC aligned with the one-cycle registered instruction read.
- Feeds the IF/ID boundary, so decode receives the instruction word, the matching PC and a valid flag.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit words in instruction memory; power of two.
- PC_W, 32, width of the word-index fetch address and byte PCs.
- RESET_PC, 0, byte address of the first fetch; word aligned.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall from decode; hold the PC and the IF/ID tag.
- redirect_valid  in  1  branch/jump taken, resolved downstream.
- redirect_target  in  PC_W  byte address of the redirect target.
- pc_out  out  PC_W  word index presented to instruction memory.
- if_id_pc  out  PC_W  byte PC of the instruction currently in the IF/ID instruction register.
- if_id_valid  out  1  IF/ID instruction is a real, non-squashed fetch.
- misalign_fault  out  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- fetch_fault  out  1  sticky bound fault; exists only with the macro, otherwise tied 0.

Behaviour:
- Reset (async assert): pc_out=RESET_PC>>2, if_id_pc=0, if_id_valid=0, misalign_fault=0, fetch_fault=0, FSM=S_BOOT.
- FSM states: S_BOOT, S_RUN, S_STALL, S_FAULT.
  - S_BOOT: exactly one cycle after reset release; pc_out holds; if_id_valid stays 0; always goes to S_RUN.
  - S_RUN: sequential next PC is pc_out+1, wrapping modulo IMEM_DEPTH. At each edge: if_id_pc <= pc_out<<2 and if_id_valid <= 1.
  - S_STALL: entered when stall=1 in S_RUN, left when stall=0. pc_out, if_id_pc and if_id_valid all hold. Memory re-reads the same word, so the IF/ID contents stay consistent.
- Latency: address presented in cycle t gives instruction, PC and valid at IF/ID in cycle t+1.
- Redirect (redirect_valid=1, target aligned), at the edge:
  - pc_out <= target>>2 masked to log2(IMEM_DEPTH) bits;
  - if_id_valid <= 0, squashing the wrong-path word captured at that same edge;
  - FSM goes to S_RUN.
  - The target instruction is valid one edge later.
- Priority, highest first: reset > fetch fault (S_FAULT) > redirect > stall > sequential. A redirect with simultaneous stall is taken; the stall is ignored that cycle.
- Misaligned redirect (target[1:0] != 0):
  - the redirect is ignored;
  - behaviour is exactly as if redirect_valid=0 (stall still honoured);
  - misalign_fault pulses 1 for one cycle.
- Redirect during S_BOOT is accepted and takes effect at that edge; S_BOOT still exits to S_RUN.
- Reset asserted mid-operation clears all state immediately, with no residual valid.

Optional Feature:
- Macro: FETCH_BOUND_CHECK_EN.
- Defined:
  - A sequential increment from IMEM_DEPTH-1, or a redirect target >= IMEM_DEPTH*4, does not wrap.
  - The FSM enters S_FAULT; fetch_fault sets sticky 1; pc_out freezes; if_id_valid <= 0.
  - Only reset leaves S_FAULT.
- Undefined: S_FAULT is unreachable, addresses wrap modulo IMEM_DEPTH, and fetch_fault is constant 0.

Decomposition:
- Shared package holds:
  - the FSM state typedef (S_BOOT/S_RUN/S_STALL/S_FAULT, 2 bits);
  - the NOP encoding constant 32'h00000033;
  - the IMEM_DEPTH default;
  - a byte-to-word shift constant of 2.
- One natural sub-module, fetch_next_pc: combinational next-PC select (priority mux, alignment check, wrap/bound check). The top keeps the registers and the FSM.

Test Plan:
- Reset release, no stall/redirect -> S_BOOT for 1 cycle; then pc_out 0,1,2,3 on successive edges; if_id_pc 0,4,8 with if_id_valid=1 from the second post-boot edge.
- stall=1 for 3 cycles with pc_out=5 -> pc_out stays 5, if_id_pc stays 16, if_id_valid stays 1; on release pc_out=6 next edge.
- redirect_valid=1, target=0x14, at pc_out=2 -> next pc_out=5 and if_id_valid=0 for one cycle; then if_id_pc=0x14 with valid=1.
- redirect target=0x0C with stall=1 in the same cycle -> redirect wins, pc_out=3; target=0x0E -> ignored, misalign_fault pulses once, pc_out increments normally.
- Run to pc_out=31 -> without the macro the next pc_out=0; with FETCH_BOUND_CHECK_EN, fetch_fault=1, pc_out frozen at 31, if_id_valid=0 until rst_n low.
- rst_n low mid-run asynchronously between edges -> outputs reset immediately without waiting for clk; restart matches the first scenario.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN       = 32'h0000_0033;
  localparam int          IMEM_DEPTH_DEF = 32;
  localparam int          BYTE_SHIFT     = 2;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/status bundle between decode-side control and the fetch PC unit.
interface fetch_pc_unit_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] pc_out;
  logic [PC_W-1:0] if_id_pc;
  logic            if_id_valid;
  logic            misalign_fault;
  logic            fetch_fault;

  modport master (
    output stall, redirect_valid, redirect_target,
    input  pc_out, if_id_pc, if_id_valid, misalign_fault, fetch_fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    output pc_out, if_id_pc, if_id_valid, misalign_fault, fetch_fault
  );
endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// Combinational next-PC select: fault hold > redirect > stall/boot hold > increment.
// Bound checking instead of wrapping is enabled by FETCH_BOUND_CHECK_EN.
module fetch_next_pc
  import fetch_pc_unit_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int PC_W       = 32
) (
  input  fetch_state_t    state,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc,
  output logic            redir_take,
  output logic            misalign,
  output logic            bound_err
);
  localparam logic [PC_W-1:0] MASK = PC_W'(IMEM_DEPTH - 1);

  logic [PC_W-1:0] tgt_word;
  logic            mis_tgt;
  logic            redir_oob;
  logic            seq_oob;

  assign tgt_word = redirect_target >> BYTE_SHIFT;
  assign mis_tgt  = |redirect_target[1:0];
  assign misalign = redirect_valid && mis_tgt && (state != S_FAULT);

`ifdef FETCH_BOUND_CHECK_EN
  assign redir_oob = tgt_word >= PC_W'(IMEM_DEPTH);
  assign seq_oob   = pc == MASK;
`else
  assign redir_oob = 1'b0;
  assign seq_oob   = 1'b0;
`endif

  always_comb begin
    next_pc    = pc;
    redir_take = 1'b0;
    bound_err  = 1'b0;
    if (state == S_FAULT) begin
      next_pc = pc;
    end else if (redirect_valid && !mis_tgt) begin
      // a misaligned target falls through as if no redirect were requested
      if (redir_oob) bound_err = 1'b1;
      else begin
        next_pc    = tgt_word & MASK;
        redir_take = 1'b1;
      end
    end else if (state == S_BOOT || stall) begin
      next_pc = pc;
    end else if (seq_oob) begin
      bound_err = 1'b1;
    end else begin
      next_pc = (pc + PC_W'(1)) & MASK;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, IF/ID tag tracking and fetch FSM.
// FETCH_BOUND_CHECK_EN turns address wrap into a sticky fetch fault.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int PC_W       = 32,
  parameter int RESET_PC   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pc_unit_if.slave   bus
);
  localparam logic [PC_W-1:0] RESET_WORD = PC_W'(RESET_PC >> BYTE_SHIFT);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] if_id_pc_q, if_id_pc_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            misalign_q, misalign_d;

  logic [PC_W-1:0] next_pc;
  logic            redir_take;
  logic            misalign;
  logic            bound_err;

  fetch_next_pc #(.IMEM_DEPTH(IMEM_DEPTH), .PC_W(PC_W)) u_next_pc (
    .state           (state_q),
    .stall           (bus.stall),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .pc              (pc_q),
    .next_pc         (next_pc),
    .redir_take      (redir_take),
    .misalign        (misalign),
    .bound_err       (bound_err)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = next_pc;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = misalign;
    unique case (state_q)
      S_BOOT: begin
        state_d       = S_RUN;
        if_id_valid_d = 1'b0;
      end
      S_RUN, S_STALL: begin
        if (redir_take) begin
          // word read at this edge is wrong-path: capture its tag but squash it
          if_id_pc_d    = pc_q << BYTE_SHIFT;
          if_id_valid_d = 1'b0;
          state_d       = S_RUN;
        end else if (bus.stall) begin
          state_d = S_STALL;
        end else begin
          if_id_pc_d    = pc_q << BYTE_SHIFT;
          if_id_valid_d = 1'b1;
          state_d       = S_RUN;
        end
      end
      S_FAULT: begin
        if_id_valid_d = 1'b0;
      end
    endcase
    if (bound_err) begin
      state_d       = S_FAULT;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_WORD;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.if_id_pc       = if_id_pc_q;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.misalign_fault = misalign_q;
`ifdef FETCH_BOUND_CHECK_EN
  // only reset leaves S_FAULT, so the state itself is the sticky flag
  assign bus.fetch_fault    = (state_q == S_FAULT);
`else
  assign bus.fetch_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit (IMEM_DEPTH=32, RESET_PC=0).
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  fetch_pc_unit_if #(.PC_W(32)) bus ();

  fetch_pc_unit #(.IMEM_DEPTH(32), .PC_W(32), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic        e_v;
    logic        e_mis;
    logic        e_ff;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic [31:0] p,
                              logic [31:0] ip, logic v, logic m, logic f);
    vec_t x;
    x.stall = s; x.rv = r; x.tgt = t; x.e_pc = p; x.e_ifpc = ip;
    x.e_v = v; x.e_mis = m; x.e_ff = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p, input logic [31:0] ip,
                         input logic v, input logic m, input logic f);
    chk({tag, ".pc_out"},   bus.pc_out, p);
    chk({tag, ".if_id_pc"}, bus.if_id_pc, ip);
    chk({tag, ".valid"},    32'(bus.if_id_valid), 32'(v));
    chk({tag, ".misalign"}, 32'(bus.misalign_fault), 32'(m));
    chk({tag, ".fetch_ft"}, 32'(bus.fetch_fault), 32'(f));
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    bus.stall = s; bus.redirect_valid = r; bus.redirect_target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0);

    // boot, sequential, redirect, stall, redirect-over-stall, misaligned
    vecs[0]  = mk(0, 0, 32'h00,  0, 32'h00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h00,  1, 32'h00, 1, 0, 0);
    vecs[2]  = mk(0, 0, 32'h00,  2, 32'h04, 1, 0, 0);
    vecs[3]  = mk(0, 1, 32'h14,  5, 32'h08, 0, 0, 0);
    vecs[4]  = mk(0, 0, 32'h00,  6, 32'h14, 1, 0, 0);
    vecs[5]  = mk(1, 0, 32'h00,  6, 32'h14, 1, 0, 0);
    vecs[6]  = mk(1, 0, 32'h00,  6, 32'h14, 1, 0, 0);
    vecs[7]  = mk(1, 0, 32'h00,  6, 32'h14, 1, 0, 0);
    vecs[8]  = mk(0, 0, 32'h00,  7, 32'h18, 1, 0, 0);
    vecs[9]  = mk(1, 1, 32'h0C,  3, 32'h1C, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h00,  4, 32'h0C, 1, 0, 0);
    vecs[11] = mk(0, 1, 32'h0E,  5, 32'h10, 1, 1, 0);
    vecs[12] = mk(0, 0, 32'h00,  6, 32'h14, 1, 0, 0);
    vecs[13] = mk(1, 1, 32'h0E,  6, 32'h14, 1, 1, 0);
    vecs[14] = mk(0, 0, 32'h00,  7, 32'h18, 1, 0, 0);
    vecs[15] = mk(0, 1, 32'h7C, 31, 32'h1C, 0, 0, 0);
`ifdef FETCH_BOUND_CHECK_EN
    vecs[16] = mk(0, 0, 32'h00, 31, 32'h1C, 0, 0, 1);
    vecs[17] = mk(0, 0, 32'h00, 31, 32'h1C, 0, 0, 1);
    vecs[18] = mk(0, 1, 32'h08, 31, 32'h1C, 0, 0, 1);
    vecs[19] = mk(0, 1, 32'h84, 31, 32'h1C, 0, 0, 1);
`else
    vecs[16] = mk(0, 0, 32'h00,  0, 32'h7C, 1, 0, 0);
    vecs[17] = mk(0, 0, 32'h00,  1, 32'h00, 1, 0, 0);
    vecs[18] = mk(0, 1, 32'h08,  2, 32'h04, 0, 0, 0);
    vecs[19] = mk(0, 1, 32'h84,  1, 32'h08, 0, 0, 0);
`endif

    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].tgt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc,
              vecs[i].e_v, vecs[i].e_mis, vecs[i].e_ff);
    end

    // asynchronous reset between edges, then redirect taken during boot
    drive(0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    drive(0, 1, 32'h10);
    step();
    chk_all("boot_redir", 4, 0, 0, 0, 0);
    drive(0, 0, 0);
    step();
    chk_all("boot_redir_tgt", 5, 32'h10, 1, 0, 0);

    // restart reproduces the initial boot sequence
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk_all("restart0", 0, 0, 0, 0, 0);
    step();
    chk_all("restart1", 1, 0, 1, 0, 0);
    step();
    chk_all("restart2", 2, 32'h04, 1, 0, 0);

`ifdef FETCH_BOUND_CHECK_EN
    drive(0, 1, 32'h80);
    step();
    chk_all("redir_oob", 2, 32'h04, 0, 0, 1);
    drive(0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
